// File: rtl/fb_port_arbiter.sv
// Time-division arbiter sharing one single-port frame-buffer RAM between a VGA
// read slot (phase 0) and NUM_WR buffered writer channels (phases 1..NUM_WR).
module fb_port_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned RD_LAT = 2,
    localparam int unsigned PH_W  = $clog2(NUM_WR + 1)
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic [NUM_WR-1:0]          wr_valid,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    output logic [NUM_WR-1:0]          wr_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_din,
    output logic                       mem_we,
    input  logic [DATA_W-1:0]          mem_dout,
    output logic [PH_W-1:0]            phase
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_WR);

    if (NUM_WR < 1) begin : g_bad_num_wr
        $error("fb_port_arbiter: NUM_WR must be at least 1");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("fb_port_arbiter: RD_LAT must be at least 1");
    end

    // active stays low for one edge after reset release so phase 0 restarts cleanly
    logic                  active;
    logic [NUM_WR-1:0]     full;
    logic [ADDR_W-1:0]     hold_addr [NUM_WR];
    logic [DATA_W-1:0]     hold_data [NUM_WR];
    logic [RD_LAT-1:0]     rd_tok;

    logic                  rd_issue_c;
    logic [NUM_WR-1:0]     slot_c;
    logic [NUM_WR-1:0]     load_c;
    logic [NUM_WR-1:0]     drain_c;

    // Slot decode and per-channel handshake
    always_comb begin
        rd_issue_c = active && (phase == '0);
        slot_c     = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            slot_c[i] = active && (phase == PH_W'(i + 1));
        end
        wr_ready = ~full | slot_c;
        load_c   = wr_valid & wr_ready;
        drain_c  = slot_c & full;
    end

    // Slot counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            active <= 1'b0;
            phase  <= '0;
        end else begin
            active <= 1'b1;
            if (active) begin
                phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            end
        end
    end

    // One-entry holding registers; a load in the drain slot keeps the entry full
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            full <= '0;
            for (int i = 0; i < NUM_WR; i++) begin
                hold_addr[i] <= '0;
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (load_c[i]) begin
                    full[i]      <= 1'b1;
                    hold_addr[i] <= wr_addr[i*ADDR_W +: ADDR_W];
                    hold_data[i] <= wr_data[i*DATA_W +: DATA_W];
                end else if (drain_c[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Read tokens travel RD_LAT stages to line up with mem_dout
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_tok   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_tok   <= (rd_tok << 1) | RD_LAT'(rd_issue_c);
            rd_valid <= rd_tok[RD_LAT-1];
            if (rd_tok[RD_LAT-1]) begin
                rd_data <= mem_dout;
            end
        end
    end

    // RAM port mux: at most one slot owns the port in any cycle
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (rd_issue_c) begin
            mem_addr = rd_addr;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (drain_c[i]) begin
                mem_addr = hold_addr[i];
                mem_din  = hold_data[i];
                mem_we   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed testbench for fb_port_arbiter with a 2-cycle-latency RAM model.
module tb_fb_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [1:0]  wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic [15:0] mem_dout;
    logic [1:0]  phase;

    logic [15:0] ram [256];
    logic [15:0] ram_q;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    int checks = 0;
    int errors = 0;
    int ph     = 0;
    bit live   = 1'b0;

    fb_port_arbiter #(.ADDR_W(16), .DATA_W(16), .NUM_WR(2), .RD_LAT(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .phase(phase)
    );

    always #5 CLK = ~CLK;

    // RAM model: address in cycle t, data on mem_dout in cycle t+2
    always @(posedge CLK) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr[7:0]] <= mem_din;
        ram_q    <= ram[mem_addr[7:0]];
        mem_dout <= ram_q;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        if (!RESET_N) begin ph = 0; live = 1'b0; end
        else if (!live) live = 1'b1;
        else ph = (ph == 2) ? 0 : ph + 1;
        #1;
    endtask

    task automatic goto_phase(input int p);
        int n = 0;
        while (ph != p && n < 8) begin step(); n++; end
        checks++;
        if (phase !== 2'(p)) begin errors++; $display("FAIL goto_phase: got %0d expected %0d", phase, p); end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; wr_valid = 2'b11; wr_addr = 32'h0001_0002; wr_data = 32'h1111_2222;
        rd_addr = 16'h0; pre_we = 1'b0; pre_addr = 8'h0; pre_data = 16'h0;
        step();
        pre_we = 1'b1; pre_addr = 8'h05; pre_data = 16'hABCD;
        step();
        pre_addr = 8'h07; pre_data = 16'h1234;
        step();
        pre_we = 1'b0;
        step();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (wr_ready !== 2'b11) begin errors++; $display("FAIL reset_wr_ready: got %b expected 11", wr_ready); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
        RESET_N = 1'b1; wr_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (phase !== 2'(k % 3)) begin errors++; $display("FAIL reset_phase_seq[%0d]: got %0d expected %0d", k, phase, k % 3); end
        end
    endtask

    task automatic test_read_latency();
        goto_phase(0);
        rd_addr = 16'h0005;
        #1;
        checks++; if (mem_addr !== 16'h0005) begin errors++; $display("FAIL rd_mem_addr: got %h expected 0005", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_t1: got %b expected 0", rd_valid); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_t2: got %b expected 0", rd_valid); end
        step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_t3: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 16'hABCD) begin errors++; $display("FAIL rd_data_t3: got %h expected abcd", rd_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_t4: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 16'hABCD) begin errors++; $display("FAIL rd_data_hold: got %h expected abcd", rd_data); end
        step();
        step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_t6: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 16'hABCD) begin errors++; $display("FAIL rd_data_t6: got %h expected abcd", rd_data); end
    endtask

    task automatic test_single_write();
        goto_phase(0);
        wr_valid = 2'b10; wr_addr = {16'h0040, 16'h0000}; wr_data = {16'h000F, 16'h0000};
        #1;
        checks++; if (wr_ready[1] !== 1'b1) begin errors++; $display("FAIL sw_ready_ph0: got %b expected 1", wr_ready[1]); end
        step();
        wr_valid = 2'b00;
        checks++; if (wr_ready[1] !== 1'b0) begin errors++; $display("FAIL sw_ready_ph1: got %b expected 0", wr_ready[1]); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sw_we_ph1: got %b expected 0", mem_we); end
        step();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we_ph2: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL sw_addr_ph2: got %h expected 0040", mem_addr); end
        checks++; if (mem_din !== 16'h000F) begin errors++; $display("FAIL sw_din_ph2: got %h expected 000f", mem_din); end
        checks++; if (wr_ready[1] !== 1'b1) begin errors++; $display("FAIL sw_ready_ph2: got %b expected 1", wr_ready[1]); end
        step();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sw_we_after: got %b expected 0", mem_we); end
        checks++; if (wr_ready !== 2'b11) begin errors++; $display("FAIL sw_ready_after: got %b expected 11", wr_ready); end
    endtask

    task automatic test_back_to_back();
        bit          rdy_t [9] = '{1, 1, 0, 0, 1, 0, 0, 1, 1};
        bit          we_t  [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
        logic [15:0] din_t [9] = '{16'd0, 16'd1, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd3, 16'd0};
        int idx = 0;
        goto_phase(0);
        for (int c = 0; c < 9; c++) begin
            wr_valid = {1'b0, idx < 3};
            wr_addr  = {16'h0000, 16'(16'h0010 + idx)};
            wr_data  = {16'h0000, 16'(idx + 1)};
            #1;
            checks++; if (wr_ready[0] !== rdy_t[c]) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, wr_ready[0], rdy_t[c]); end
            checks++; if (mem_we !== we_t[c]) begin errors++; $display("FAIL b2b_we[%0d]: got %b expected %b", c, mem_we, we_t[c]); end
            if (we_t[c]) begin
                checks++; if (mem_din !== din_t[c]) begin errors++; $display("FAIL b2b_din[%0d]: got %h expected %h", c, mem_din, din_t[c]); end
                checks++; if (mem_addr !== 16'h000F + din_t[c]) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", c, mem_addr, 16'h000F + din_t[c]); end
            end
            if (idx < 3 && rdy_t[c]) idx++;
            step();
        end
        wr_valid = 2'b00;
    endtask

    task automatic test_collision();
        goto_phase(0);
        rd_addr = 16'h0000;
        wr_valid = 2'b11; wr_addr = {16'h0007, 16'h0007}; wr_data = {16'h00FF, 16'h0003};
        step();
        wr_valid = 2'b00;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0007 || mem_din !== 16'h0003) begin errors++; $display("FAIL col_slot1: got we=%b addr=%h din=%h expected we=1 addr=0007 din=0003", mem_we, mem_addr, mem_din); end
        step();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0007 || mem_din !== 16'h00FF) begin errors++; $display("FAIL col_slot2: got we=%b addr=%h din=%h expected we=1 addr=0007 din=00ff", mem_we, mem_addr, mem_din); end
        step();
        rd_addr = 16'h0007;
        step(); step(); step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL col_rd_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 16'h00FF) begin errors++; $display("FAIL col_rd_data: got %h expected 00ff", rd_data); end
    endtask

    task automatic test_no_bypass();
        goto_phase(2);
        wr_valid = 2'b01; wr_addr = {16'h0000, 16'h0005}; wr_data = {16'h0000, 16'h5555};
        #1;
        checks++; if (wr_ready[0] !== 1'b1) begin errors++; $display("FAIL nb_ready_ph2: got %b expected 1", wr_ready[0]); end
        step();
        wr_valid = 2'b00; rd_addr = 16'h0005;
        #1;
        checks++; if (wr_ready[0] !== 1'b0) begin errors++; $display("FAIL nb_ready_ph0: got %b expected 0", wr_ready[0]); end
        checks++; if (mem_addr !== 16'h0005 || mem_we !== 1'b0) begin errors++; $display("FAIL nb_ph0_port: got addr=%h we=%b expected addr=0005 we=0", mem_addr, mem_we); end
        step();
        checks++; if (mem_we !== 1'b1 || mem_din !== 16'h5555) begin errors++; $display("FAIL nb_write: got we=%b din=%h expected we=1 din=5555", mem_we, mem_din); end
        step(); step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hABCD) begin errors++; $display("FAIL nb_old_data: got valid=%b data=%h expected valid=1 data=abcd", rd_valid, rd_data); end
        step(); step(); step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h5555) begin errors++; $display("FAIL nb_new_data: got valid=%b data=%h expected valid=1 data=5555", rd_valid, rd_data); end
    endtask

    task automatic test_mid_reset();
        goto_phase(0);
        rd_addr = 16'h0005;
        step();
        wr_valid = 2'b01; wr_addr = {16'h0000, 16'h0020}; wr_data = {16'h0000, 16'h7777};
        #1;
        checks++; if (wr_ready[0] !== 1'b1) begin errors++; $display("FAIL mr_accept: got %b expected 1", wr_ready[0]); end
        step();
        wr_valid = 2'b00;
        checks++; if (wr_ready[0] !== 1'b0) begin errors++; $display("FAIL mr_full: got %b expected 0", wr_ready[0]); end
        RESET_N = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || wr_ready !== 2'b11 || phase !== 2'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mr_async: got we=%b ready=%b phase=%0d valid=%b expected 0 11 0 0", mem_we, wr_ready, phase, rd_valid); end
        step(); step();
        RESET_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mr_we[%0d]: got %b expected 0", c, mem_we); end
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mr_valid[%0d]: got %b expected 0", c, rd_valid); end
            checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL mr_data[%0d]: got %h expected 0000", c, rd_data); end
            if (c < 3) step();
        end
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL mr_phase: got %0d expected 2", phase); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_single_write();
        test_back_to_back();
        test_collision();
        test_no_bypass();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Time-division arbiter for one single-port on-chip frame-buffer RAM, shared by one VGA read channel and NUM_WR ray-tracing writer channels. Phase 0 of each round is the VGA read slot; phases 1..NUM_WR belong to writers 0..NUM_WR-1. Each writer has a one-entry holding register with valid/ready handshake, so cores need not know the slot schedule. Read data is returned through a latency-matched pipeline into a registered pixel buffer.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 16, RAM data width
NUM_WR, 2, number of writer channels (>=1)
RD_LAT, 2, RAM read latency in cycles from address to valid mem_dout (>=1)

Ports:
CLK  in  1  system clock (MAIN_CLK domain)
RESET_N  in  1  asynchronous reset, active low
rd_addr  in  ADDR_W  VGA read address, sampled in phase 0
rd_data  out  DATA_W  registered read result
rd_valid  out  1  one-cycle pulse when rd_data updates
wr_valid  in  NUM_WR  per-channel write request
wr_addr  in  NUM_WR*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
wr_data  in  NUM_WR*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
wr_ready  out  NUM_WR  per-channel accept
mem_addr  out  ADDR_W  RAM address
mem_din  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_dout  in  DATA_W  RAM read data
phase  out  clog2(NUM_WR+1)  current slot index

Behaviour:
- One clock (CLK); reset asynchronous, active low (RESET_N). All state clears on RESET_N low regardless of clock.
- Reset values: phase=0, all holding registers empty, read pipeline empty, rd_data=0, rd_valid=0, wr_ready=all ones, mem_we=0, mem_addr=0, mem_din=0.
- phase increments by 1 each cycle, wraps NUM_WR -> 0; round length NUM_WR+1 cycles.
- Phase 0: mem_addr=rd_addr (combinational), mem_we=0, mem_din=0; read token enters RD_LAT-deep pipeline.
- Token emerging at cycle t+RD_LAT (read issued at t): rd_data <= mem_dout at that edge; rd_valid=1 during cycle t+RD_LAT+1 only. rd_data holds between reads.
- Phase k in 1..NUM_WR, channel i=k-1: if hold[i] full: mem_addr=hold_addr[i], mem_din=hold_data[i], mem_we=1, hold[i] empties at edge. If empty: mem_addr=0, mem_din=0, mem_we=0.
- wr_ready[i] = ~full[i] | (phase==i+1). No combinational path from wr_valid to wr_ready.
- Transfer on wr_valid[i] & wr_ready[i] at edge: hold[i] loads wr_addr/wr_data and becomes full.
- Simultaneous drain and load on channel i: old entry written to RAM this cycle, new entry captured; hold stays full.
- Writes never reorder within a channel; across channels RAM order follows slot order.
- Same address written by two channels in one round: later slot wins.
- Read in phase 0 of an address held (not yet written): returns old RAM contents; no bypass.
- Worst-case write latency acceptance->RAM write: NUM_WR+1 cycles. Sustained per-channel throughput: one write per round.
- Reset mid-operation: pending holds discarded, in-flight read tokens dropped (no rd_valid), phase restarts at 0 on first edge after RESET_N rises.
- mem_we asserted only in phases 1..NUM_WR; never in phase 0.

Test Plan:
- Reset: hold RESET_N low 3 cycles with wr_valid=2'b11 -> mem_we=0, rd_valid=0, wr_ready=2'b11, phase=0; release -> phase 0,1,2,0...
- Read latency (NUM_WR=2, RD_LAT=2): RAM model preloaded addr 5 = 16'hABCD, rd_addr=5 in phase 0 at cycle t -> rd_data=16'hABCD, rd_valid pulse at cycle t+3 only, repeating every 3 cycles.
- Single write: channel 1 offers addr 16'h0040 data 16'h000F in phase 0 -> accepted, hold full, wr_ready[1]=0 during phase 1, mem_we=1 mem_addr=16'h0040 mem_din=16'h000F in phase 2, wr_ready[1]=1.
- Back-to-back: channel 0 wr_valid held high with data 1,2,3 -> exactly one accept and one RAM write per round, order 1,2,3, no drops or duplicates.
- Collision: channels 0 and 1 both write addr 7 (data 16'h0003, 16'h00FF) in same round; then read addr 7 -> rd_data=16'h00FF.
- Mid-operation reset: assert RESET_N low while hold[0] full and a read token in flight -> no subsequent mem_we for that entry, no rd_valid, rd_data=0.
